// File: rtl/result_requant_drain.sv
// result_requant_drain: snapshots 16 Q16.16 accumulators, requantises
// them to Q8.8 with rounding and saturation, then streams the words out.
module result_requant_drain #(
   parameter int ACC_W = 32,
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int AW    = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                done,
   input  logic [16*ACC_W-1:0] c_bus,
   output logic [DW-1:0]       out_data,
   output logic [3:0]          out_idx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                frame_done,
   output logic                busy,
   output logic [4:0]          sat_cnt,
   output logic                overrun,
   input  logic [AW-1:0]       addr_out,
   input  logic                oe,
   output logic [DW-1:0]       rdata
);

   typedef enum logic [1:0] {IDLE, CONVERT, STREAM} state_t;

   localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) << (FRAC-1);
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (DW-1)) - 1);
   localparam logic signed [ACC_W:0] MINV = ~MAXV;
   localparam logic [DW-1:0] SAT_P = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_N = {1'b1, {(DW-1){1'b0}}};

   state_t state, state_nx;
   logic [3:0]       idx;
   logic [ACC_W-1:0] cap     [16];
   logic [DW-1:0]    res_buf [16];

   logic signed [ACC_W:0] rq_sum;
   logic signed [ACC_W:0] rq_y;
   logic [DW-1:0]         rq_word;
   logic                  rq_sat;
   logic                  last_hs;

   assign last_hs = out_valid && out_ready && (out_idx == 4'd15);

   // round-half-up then arithmetic shift, widened by one bit so the
   // rounding add can never wrap; clamp to the signed DW range
   always_comb begin
      rq_sum  = $signed({cap[idx][ACC_W-1], cap[idx]}) + RND;
      rq_y    = rq_sum >>> FRAC;
      rq_word = rq_y[DW-1:0];
      rq_sat  = 1'b0;
      if (rq_y > MAXV) begin
         rq_word = SAT_P;
         rq_sat  = 1'b1;
      end else if (rq_y < MINV) begin
         rq_word = SAT_N;
         rq_sat  = 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // next-state: convert 16 words, then stream until the last accept
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (done) state_nx = CONVERT;
         CONVERT: if (idx == 4'd15) state_nx = STREAM;
         STREAM:  if (last_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy = (state != IDLE);
   end

   // capture, conversion, stream and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         out_data   <= '0;
         out_idx    <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         sat_cnt    <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            cap[i]     <= '0;
            res_buf[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         if (done && state != IDLE) overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (done) begin
                  for (int i = 0; i < 16; i++)
                     cap[i] <= c_bus[i*ACC_W +: ACC_W];
                  sat_cnt <= '0;
                  idx     <= '0;
               end
            end
            CONVERT: begin
               res_buf[idx] <= rq_word;
               if (rq_sat) sat_cnt <= sat_cnt + 5'd1;
               idx <= idx + 4'd1;
            end
            STREAM: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_data  <= res_buf[0];
               end else if (out_ready) begin
                  if (out_idx == 4'd15) begin
                     out_valid  <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     out_idx  <= out_idx + 4'd1;
                     out_data <= res_buf[out_idx + 4'd1];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // registered random-read port; out-of-range addresses read as zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (oe) begin
         if (addr_out < AW'(16)) rdata <= res_buf[addr_out[3:0]];
         else                    rdata <= '0;
      end
   end

endmodule

// File: tb/tb_result_requant_drain.sv
// tb_result_requant_drain: directed and randomised frames checked
// against an arithmetic requantisation model.
module tb_result_requant_drain;

   logic         clk;
   logic         rst;
   logic         done;
   logic [511:0] c_bus;
   logic [15:0]  out_data;
   logic [3:0]   out_idx;
   logic         out_valid;
   logic         out_ready;
   logic         frame_done;
   logic         busy;
   logic [4:0]   sat_cnt;
   logic         overrun;
   logic [6:0]   addr_out;
   logic         oe;
   logic [15:0]  rdata;

   int checks;
   int errors;
   logic [15:0] last_exp [16];

   result_requant_drain dut (
      .clk(clk), .rst(rst), .done(done), .c_bus(c_bus),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .frame_done(frame_done), .busy(busy),
      .sat_cnt(sat_cnt), .overrun(overrun), .addr_out(addr_out),
      .oe(oe), .rdata(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Q16.16 -> Q8.8: add half an LSB, floor-divide by 256, clamp
   function automatic logic [15:0] rq_model(input logic [31:0] x,
                                            output int sat);
      longint v;
      longint y;
      v = longint'($signed(x));
      y = (v + 128) >>> 8;
      sat = 0;
      if (y > 32767) begin
         sat = 1;
         return 16'h7FFF;
      end
      if (y < -32768) begin
         sat = 1;
         return 16'h8000;
      end
      return 16'(y);
   endfunction

   function automatic logic [511:0] rand_bus();
      logic [511:0] b;
      logic [31:0]  w;
      logic [31:0]  edge_v [8];
      edge_v = '{32'h007FFF7F, 32'h007FFF80, 32'hFF7FFF80, 32'hFF7FFF7F,
                 32'h00000080, 32'hFFFFFF80, 32'hFFFFFF7F, 32'h00000000};
      b = '0;
      for (int i = 0; i < 16; i++) begin
         w = $urandom();
         case (int'($urandom_range(0, 3)))
            0: b[i*32 +: 32] = w;
            1: b[i*32 +: 32] = {{8{w[23]}}, w[23:0]};
            2: b[i*32 +: 32] = edge_v[$urandom_range(0, 7)];
            default: b[i*32 +: 32] = {{16{w[15]}}, w[15:0]};
         endcase
      end
      return b;
   endfunction

   // rmode: 0 ready always, 1 ready 1,0,0 repeating, 2 random ready
   task automatic run_frame(input logic [511:0] bus, input int rmode,
                            input bit inj, input bit started,
                            input bit chain, input logic [511:0] nbus);
      logic [15:0] ew [16];
      int sat;
      int exp_sat;
      int n;
      int cyc;
      int rc;
      bit fd;
      bit seen_v;
      exp_sat = 0;
      for (int i = 0; i < 16; i++) begin
         ew[i] = rq_model(bus[i*32 +: 32], sat);
         exp_sat += sat;
      end
      if (!started) begin
         c_bus = bus;
         done  = 1'b1;
      end
      n = 0;
      cyc = -1;
      rc = 0;
      fd = 1'b0;
      seen_v = 1'b0;
      while (!fd && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         done = 1'b0;
         if (cyc == 0) begin
            chk("busy_rise", 32'(busy), 32'd1);
            chk("fd_pulse_len", 32'(frame_done), 32'd0);
         end
         if (inj && (cyc == 5 || cyc == 25)) begin
            c_bus = rand_bus();
            done  = 1'b1;
         end
         if (frame_done) begin
            fd = 1'b1;
            chk("fd_count", 32'(n), 32'd16);
            chk("fd_valid", 32'(out_valid), 32'd0);
            chk("fd_busy", 32'(busy), 32'd0);
            chk("sat_cnt", 32'(sat_cnt), 32'(exp_sat));
            if (rmode == 0) chk("fd_latency", 32'(cyc), 32'd33);
            if (chain) begin
               c_bus = nbus;
               done  = 1'b1;
            end
         end else if (out_valid) begin
            if (!seen_v) begin
               seen_v = 1'b1;
               chk("valid_latency", 32'(cyc), 32'd17);
            end
            if (n >= 16) begin
               chk("extra_word", 32'(n), 32'd15);
            end else begin
               chk("out_idx", 32'(out_idx), 32'(n));
               chk("out_data", 32'(out_data), 32'(ew[n]));
            end
            case (rmode)
               0: out_ready = 1'b1;
               1: out_ready = (rc % 3 == 0);
               default: out_ready = 1'($urandom_range(0, 1));
            endcase
            rc++;
            if (out_ready) n++;
         end
      end
      if (!fd) chk("fd_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 16; i++) last_exp[i] = ew[i];
   endtask

   task automatic read_chk(input string tag, input logic [6:0] a,
                           input logic [15:0] exp);
      oe = 1'b1;
      addr_out = a;
      @(posedge clk); #1;
      oe = 1'b0;
      chk(tag, 32'(rdata), 32'(exp));
   endtask

   initial begin : main
      logic [511:0] bus_a;
      logic [511:0] bus_b;
      logic [511:0] b1;
      logic [511:0] b2;
      logic [6:0]   ra;
      logic [15:0]  hold;
      int           cyc;
      logic [31:0]  words [7];

      checks = 0;
      errors = 0;
      rst = 1'b0;
      done = 1'b0;
      c_bus = '0;
      out_ready = 1'b1;
      addr_out = '0;
      oe = 1'b0;

      for (int i = 0; i < 16; i++) bus_a[i*32 +: 32] = 32'h0004EC40;
      words = '{32'h000C5310, 32'h00000080, 32'hFFFFFF80, 32'hFFFFFF7F,
                32'h00800000, 32'hFF000000, 32'h007FFF7F};
      bus_b = '0;
      for (int i = 0; i < 7; i++) bus_b[i*32 +: 32] = words[i];

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_frame(bus_a, 0, 1'b0, 1'b0, 1'b1, bus_b);
      run_frame(bus_b, 0, 1'b0, 1'b1, 1'b0, '0);
      chk("chain_overrun", 32'(overrun), 32'd0);
      read_chk("rd_c1", 7'd0, 16'h0C53);
      read_chk("rd_c2", 7'd1, 16'h0001);
      read_chk("rd_c3", 7'd2, 16'h0000);
      read_chk("rd_c4", 7'd3, 16'hFFFF);
      read_chk("rd_c5", 7'd4, 16'h7FFF);
      read_chk("rd_c6", 7'd5, 16'h8000);
      read_chk("rd_c7", 7'd6, 16'h7FFF);

      for (int k = 0; k < 3; k++)
         run_frame(rand_bus(), 1, 1'b0, 1'b0, 1'b0, '0);
      for (int k = 0; k < 3; k++)
         run_frame(rand_bus(), 2, 1'b0, 1'b0, 1'b0, '0);
      chk("no_overrun", 32'(overrun), 32'd0);

      b1 = rand_bus();
      b2 = rand_bus();
      run_frame(b1, 0, 1'b1, 1'b0, 1'b1, b2);
      chk("overrun_set", 32'(overrun), 32'd1);
      run_frame(b2, 2, 1'b0, 1'b1, 1'b0, '0);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      read_chk("rd_0", 7'd0, last_exp[0]);
      read_chk("rd_1", 7'd1, last_exp[1]);
      read_chk("rd_2", 7'd2, last_exp[2]);
      read_chk("rd_3", 7'd3, last_exp[3]);
      read_chk("rd_20", 7'd20, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         ra = 7'($urandom_range(0, 127));
         read_chk("rd_rand", ra, (ra < 7'd16) ? last_exp[ra[3:0]] : 16'h0000);
      end
      read_chk("rd_pre_hold", 7'd5, last_exp[5]);
      hold = last_exp[5];
      addr_out = 7'd9;
      @(posedge clk); #1;
      chk("rd_hold", 32'(rdata), 32'(hold));

      c_bus = bus_a;
      done = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      done = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid_valid", 32'(out_valid), 32'd1);
      read_chk("mid_rdata", 7'd0, 16'h04EC);
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_rdata", 32'(rdata), 32'd0);
      chk("mrst_data", 32'(out_data), 32'd0);
      chk("mrst_overrun", 32'(overrun), 32'd0);
      chk("mrst_fd", 32'(frame_done), 32'd0);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_fd", 32'(frame_done), 32'd0);

      run_frame(rand_bus(), 2, 1'b0, 1'b0, 1'b0, '0);
      chk("post_rst_overrun", 32'(overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_requant_drain.md
Name: result_requant_drain

Overview:
- Downstream stage of the 4x4 systolic array (top_overall).
- On the array's done pulse it snapshots all 16 signed 32-bit accumulators (c1..c16), requantises each from Q16.16 to Q8.8 with rounding and saturation, and stores the results in a 16-entry result buffer.
- It then streams the buffer out over a valid/ready port.
- A 7-bit addr_out/oe random-read port is also provided for bench and debug inspection.

Parameters:
- ACC_W, 32, accumulator width of each PE result
- DW, 16, output word width (Q8.8)
- FRAC, 8, right-shift applied during requantisation
- AW, 7, address width of the random-read port

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- done  in  1  one-cycle pulse from the array; c_bus is valid in the same cycle
- c_bus  in  16*ACC_W  packed accumulators; c1 at [31:0], c16 at [511:480]; row-major (c1..c4 = row 0)
- out_data  out  DW  streamed result word
- out_idx  out  4  index (0..15) of out_data
- out_valid  out  1  stream valid
- out_ready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse after the 16th stream handshake
- busy  out  1  high in CONVERT or STREAM
- sat_cnt  out  5  number of saturated words in the current frame (0..16)
- overrun  out  1  sticky; done arrived while busy
- addr_out  in  AW  random-read address
- oe  in  1  random-read enable
- rdata  out  DW  random-read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs are 0: out_data, out_idx, out_valid, frame_done, busy, sat_cnt, overrun, rdata.
  - Capture registers and result buffer are cleared to 0.
- States: IDLE -> CONVERT -> STREAM -> IDLE.
- IDLE, done=1 at edge T:
  - latch c_bus into the capture bank;
  - clear sat_cnt;
  - go to CONVERT with idx=0.
  - busy=1 from T+1.
- CONVERT: one word per cycle, buffer[idx] <= rq(cap[idx]), idx++.
  - 16 cycles (T+1..T+16).
  - sat_cnt increments on each saturated word.
  - After idx=15, go to STREAM.
- rq(x), signed arithmetic:
  - y = (x + 2^(FRAC-1)) >>> FRAC, computed in ACC_W+1 bits so no overflow occurs.
  - If y > 32767, out = 0x7FFF and the word is saturated.
  - If y < -32768, out = 0x8000 and the word is saturated.
  - Otherwise out = y[15:0].
- STREAM:
  - out_valid=1 first visible after edge T+17, with out_idx=0 and out_data=buffer[0].
  - On out_valid&&out_ready at an edge, advance the index.
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
  - The 16th handshake drops out_valid, pulses frame_done for one cycle, and returns to IDLE; busy falls in the same cycle.
  - A new done in that same IDLE cycle is accepted.
- Throughput: with out_ready held high, words stream one per cycle. Minimum done-to-frame_done is 33 cycles.
- done while busy: ignored. Capture bank and buffer are unaffected; overrun is set and stays set until reset.
- Random-read port:
  - Registered, 1-cycle latency: if oe=1 at an edge, rdata <= buffer[addr_out[3:0]] when addr_out<16, else 0.
  - oe=0 holds rdata.
  - Legal in any state. During CONVERT it returns the buffer contents as of that edge (old or newly written word).
- Reset mid-frame: immediate return to IDLE with all outputs at 0. No frame_done is issued.

Test Plan:
- Each cap = 0x0004EC40 (4x 0x011c*0x011c), done pulse, out_ready=1 -> 16 words 0x04EC, idx 0..15 on consecutive cycles, valid from T+17, frame_done on the 33rd cycle, sat_cnt=0.
- c1 = 0x000C5310 (row 0x011c,0x0239,0x0355,0x0472 dotted with 0x011c), c2 = 0x00000080, c3 = 0xFFFFFF80, c4 = 0xFFFFFF7F -> words 0x0C53, 0x0001, 0x0000, 0xFFFF.
- c5 = 0x00800000, c6 = 0xFF000000, c7 = 0x007FFF7F, others 0 -> 0x7FFF, 0x8000, 0x7FFF, sat_cnt=2 (c7 rounds to exactly 32767, not saturated).
- Backpressure: out_ready toggles 1,0,0,1... -> no word lost or duplicated; out_data stable during stalls; frame_done only after the 16th accept.
- done re-asserted during CONVERT and during STREAM -> overrun=1, streamed data unchanged. done on the frame_done cycle -> new frame starts and overrun is unchanged.
- After a frame, oe=1 with addr_out 0,1,2,3,20 -> rdata one cycle later equals buffer[0..3], then 0. rst=0 asserted in mid-STREAM -> out_valid, busy and rdata go to 0 immediately.
